// File: rtl/uart_led_cmd.sv
// rtl/uart_led_cmd.sv - ASCII colour/duty command front end driving RGB PWM outputs
//
// Pops bytes from the simpleuart register port, parses R/G/B/W + two hex digit duty
// commands (and X = all off), answers 'K' or '?' over the same port, and generates
// 8-bit PWM for the three RGB driver inputs.
// Optional feature macro: UART_LED_ECHO_EN (echo every popped byte before the response).
//
// Ports:
//   hw_clk        system clock
//   rst           asynchronous reset, active-high
//   reg_dat_do    simpleuart read data, all-ones when no byte is buffered
//   reg_dat_wait  simpleuart write stall
//   reg_dat_re    one-cycle pop strobe
//   reg_dat_we    write request, held until accepted
//   reg_dat_di    write data {24'b0, char}
//   rgb_red       PWM to RGB0PWM
//   rgb_green     PWM to RGB1PWM
//   rgb_blue      PWM to RGB2PWM
module uart_led_cmd #(
    parameter int unsigned PWM_PRESCALE = 47,
    parameter logic [7:0]  RESET_DUTY   = 8'h00
) (
    input  logic        hw_clk,
    input  logic        rst,
    input  logic [31:0] reg_dat_do,
    input  logic        reg_dat_wait,
    output logic        reg_dat_re,
    output logic        reg_dat_we,
    output logic [31:0] reg_dat_di,
    output logic        rgb_red,
    output logic        rgb_green,
    output logic        rgb_blue
);
    localparam int PW = (PWM_PRESCALE < 1) ? 1 : $clog2(PWM_PRESCALE + 1);
    localparam logic [PW-1:0] PRESC_TC = PW'(PWM_PRESCALE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_POP     = 3'd1,
        S_PARSE   = 3'd2,
        S_TX      = 3'd3
`ifdef UART_LED_ECHO_EN
        ,S_TX_ECHO = 3'd4
`endif
    } state_t;

    typedef enum logic [1:0] {PH_CMD = 2'd0, PH_HI = 2'd1, PH_LO = 2'd2} phase_t;

    state_t      state, state_nxt;
    phase_t      phase, phase_nxt;
    logic [7:0]  rx_byte, tx_char, ch_up;
    logic [1:0]  target, tgt_code;
    logic [3:0]  hi_nib, nib;
    logic        byte_valid, is_hex, cmd_tgt_ok, is_ws;
    logic        resp_valid, tgt_load, hi_load;
    logic [7:0]  resp_char, duty_val;
    logic [2:0]  duty_mask;
    logic [7:0]  pend_r, pend_g, pend_b, pend_r_nxt, pend_g_nxt, pend_b_nxt;
    logic [7:0]  act_r, act_g, act_b;
    logic [PW-1:0] presc;
    logic [7:0]  step;
    logic        presc_tc, wrap;

    assign byte_valid = (reg_dat_do != 32'hFFFF_FFFF);

    // State register
    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (byte_valid) state_nxt = S_POP;
`ifdef UART_LED_ECHO_EN
            S_POP:     state_nxt = S_TX_ECHO;
            S_TX_ECHO: if (!reg_dat_wait) state_nxt = S_PARSE;
`else
            S_POP:     state_nxt = S_PARSE;
`endif
            S_PARSE:   state_nxt = resp_valid ? S_TX : S_IDLE;
            S_TX:      if (!reg_dat_wait) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output logic; the pop strobe is masked during reset so it reads 0 while rst is high
    always_comb begin
        reg_dat_re = (state == S_IDLE) && byte_valid && !rst;
`ifdef UART_LED_ECHO_EN
        reg_dat_we = (state == S_TX) || (state == S_TX_ECHO);
`else
        reg_dat_we = (state == S_TX);
`endif
        reg_dat_di = {24'h0, tx_char};
    end

    // Character classification on the latched byte (case-folded)
    always_comb begin
        ch_up      = (rx_byte >= 8'h61 && rx_byte <= 8'h7A) ? rx_byte - 8'h20 : rx_byte;
        is_hex     = (ch_up >= "0" && ch_up <= "9") || (ch_up >= "A" && ch_up <= "F");
        nib        = (ch_up <= "9") ? ch_up[3:0] : ch_up[3:0] + 4'd9;
        is_ws      = (rx_byte == 8'h0D) || (rx_byte == 8'h0A) || (rx_byte == 8'h20);
        cmd_tgt_ok = 1'b1;
        case (ch_up)
            "R":     tgt_code = 2'd0;
            "G":     tgt_code = 2'd1;
            "B":     tgt_code = 2'd2;
            "W":     tgt_code = 2'd3;
            default: begin tgt_code = 2'd0; cmd_tgt_ok = 1'b0; end
        endcase
    end

    // Parser: only acts during the single PARSE cycle
    always_comb begin
        resp_valid = 1'b0;
        resp_char  = 8'h00;
        phase_nxt  = phase;
        tgt_load   = 1'b0;
        hi_load    = 1'b0;
        duty_mask  = 3'b000;
        duty_val   = {hi_nib, nib};
        if (state == S_PARSE) begin
            case (phase)
                PH_CMD: begin
                    if (cmd_tgt_ok) begin
                        tgt_load  = 1'b1;
                        phase_nxt = PH_HI;
                    end else if (ch_up == "X") begin
                        duty_mask  = 3'b111;
                        duty_val   = 8'h00;
                        resp_valid = 1'b1;
                        resp_char  = "K";
                    end else if (!is_ws) begin
                        resp_valid = 1'b1;
                        resp_char  = "?";
                    end
                end
                PH_HI: begin
                    resp_valid = !is_hex;
                    resp_char  = "?";
                    hi_load    = is_hex;
                    phase_nxt  = is_hex ? PH_LO : PH_CMD;
                end
                PH_LO: begin
                    resp_valid = 1'b1;
                    resp_char  = is_hex ? "K" : "?";
                    if (is_hex) duty_mask = (target == 2'd3) ? 3'b111 : (3'b001 << target);
                    phase_nxt  = PH_CMD;
                end
                default: phase_nxt = PH_CMD;
            endcase
        end
    end

    assign pend_r_nxt = duty_mask[0] ? duty_val : pend_r;
    assign pend_g_nxt = duty_mask[1] ? duty_val : pend_g;
    assign pend_b_nxt = duty_mask[2] ? duty_val : pend_b;

    assign presc_tc = (presc == PRESC_TC);
    assign wrap     = presc_tc && (step == 8'hFF);

    // Datapath: byte/response registers, parser state, duties and PWM
    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            rx_byte   <= 8'h00;
            tx_char   <= 8'h00;
            phase     <= PH_CMD;
            target    <= 2'd0;
            hi_nib    <= 4'h0;
            pend_r    <= RESET_DUTY;
            pend_g    <= RESET_DUTY;
            pend_b    <= RESET_DUTY;
            act_r     <= RESET_DUTY;
            act_g     <= RESET_DUTY;
            act_b     <= RESET_DUTY;
            presc     <= '0;
            step      <= 8'h00;
            rgb_red   <= 1'b0;
            rgb_green <= 1'b0;
            rgb_blue  <= 1'b0;
        end else begin
            if (state == S_IDLE && byte_valid) rx_byte <= reg_dat_do[7:0];
`ifdef UART_LED_ECHO_EN
            if (state == S_POP) tx_char <= rx_byte;
`endif
            if (resp_valid) tx_char <= resp_char;
            phase <= phase_nxt;
            if (tgt_load) target <= tgt_code;
            if (hi_load)  hi_nib <= nib;
            pend_r <= pend_r_nxt;
            pend_g <= pend_g_nxt;
            pend_b <= pend_b_nxt;
            // Load from the next-pending value so a write landing on the wrap is taken now
            if (wrap) begin
                act_r <= pend_r_nxt;
                act_g <= pend_g_nxt;
                act_b <= pend_b_nxt;
            end
            presc <= presc_tc ? '0 : presc + 1'b1;
            if (presc_tc) step <= step + 8'd1;
            rgb_red   <= (step < act_r);
            rgb_green <= (step < act_g);
            rgb_blue  <= (step < act_b);
        end
    end
endmodule
